// File: rtl/lzx_74hc_down_counter_pkg.sv
// Shared definitions for the lzx counter library.
// Nibble type and helpers used by the cascadable counter stages.
package lzx_cnt_pkg;

    localparam int NIBBLE = 4;

    typedef logic [NIBBLE-1:0] nibble_t;

    function automatic logic is_zero(nibble_t n);
        return (n == '0);
    endfunction

endpackage

// File: rtl/lzx_74hc_down_counter_if.sv
// Control and status bundle of the presettable down counter.
// The master drives enables, load and preset; the slave returns Q, TC, DONE.
interface lzx_74hc_down_counter_if #(
    parameter int WIDTH = 4
);

    logic             CEP_n;
    logic             CET_n;
    logic             PE_n;
    logic             AUTO;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             TC;
    logic             DONE;

    modport master (
        output CEP_n, CET_n, PE_n, AUTO, D,
        input  Q, TC, DONE
    );

    modport slave (
        input  CEP_n, CET_n, PE_n, AUTO, D,
        output Q, TC, DONE
    );

endinterface

// File: rtl/lzx_74hc_down_counter_nibble.sv
// One 4-bit down-counting stage of the cascadable counter.
// wrap selects the reload value instead of the natural wrap to F.
module lzx_down_nibble
    import lzx_cnt_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    load,
    input  logic    step,
    input  nibble_t reload_val,
    input  logic    wrap,
    output nibble_t q,
    output logic    zero
);

    nibble_t q_q;
    nibble_t q_d;

    // Preset wins over borrow-in; a borrow steps the nibble down by one.
    always_comb begin
        q_d = q_q;
        if (load || wrap) begin
            q_d = reload_val;
        end else if (step) begin
            q_d = q_q - 4'd1;
        end
    end

    // Nibble state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q    = q_q;
    assign zero = is_zero(q_q);

endmodule

// File: rtl/lzx_74hc_down_counter.sv
// Presettable synchronous binary down counter with auto-reload.
// WIDTH/4 nibble stages; borrow ripples combinationally within one edge.
module lzx_74hc_down_counter
    import lzx_cnt_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input logic                    CP,
    input logic                    MR,
    lzx_74hc_down_counter_if.slave bus
);

    localparam int NSTG = WIDTH / NIBBLE;

    logic             cnt_en;
    logic             all_zero;
    logic             underflow;
    logic             done_q;
    logic             done_d;
    logic [NSTG-1:0]  zero;
    logic [NSTG:0]    low_zero;
    logic [WIDTH-1:0] q;

    // A count step needs both enables and no parallel load this edge.
    assign cnt_en      = bus.PE_n && !bus.CEP_n && !bus.CET_n;
    assign low_zero[0] = 1'b1;
    assign all_zero    = low_zero[NSTG];
    assign underflow   = cnt_en && all_zero;

    for (genvar i = 0; i < NSTG; i++) begin : g_stage
        assign low_zero[i+1] = low_zero[i] & zero[i];

        lzx_down_nibble u_nib (
            .clk        (CP),
            .rst        (MR),
            .load       (!bus.PE_n),
            .step       (cnt_en && low_zero[i]),
            .reload_val (bus.D[i*NIBBLE +: NIBBLE]),
            .wrap       (underflow && bus.AUTO),
            .q          (q[i*NIBBLE +: NIBBLE]),
            .zero       (zero[i])
        );
    end

    // DONE marks the cycle following an underflow step.
    always_comb begin
        done_d = underflow;
    end

    // Registered DONE pulse; reset discards any pending pulse.
    always_ff @(posedge CP) begin
        if (MR) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end

    assign bus.Q    = q;
    assign bus.TC   = all_zero && !bus.CET_n;
    assign bus.DONE = done_q;

endmodule

// File: tb/tb_lzx_74hc_down_counter.sv
// Self-checking bench for the down counter (WIDTH 4 and 8).
// Spec-level model checked every cycle plus literal expectations.
module tb_lzx_74hc_down_counter;

    logic CP = 1'b0;
    logic MR;

    always #5 CP = ~CP;

    lzx_74hc_down_counter_if #(.WIDTH(4)) b4 ();
    lzx_74hc_down_counter_if #(.WIDTH(8)) b8 ();

    lzx_74hc_down_counter #(.WIDTH(4)) dut4 (
        .CP  (CP),
        .MR  (MR),
        .bus (b4.slave)
    );

    lzx_74hc_down_counter #(.WIDTH(8)) dut8 (
        .CP  (CP),
        .MR  (MR),
        .bus (b8.slave)
    );

    int total  = 0;
    int passed = 0;

    int unsigned m4 = 0;
    int unsigned m8 = 0;
    bit          d4 = 0;
    bit          d8 = 0;

    task automatic check(input string name, input int unsigned act,
                         input int unsigned exp);
        total++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("FAIL %s actual=%0h required=%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic int unsigned nxt(
        input int unsigned q, input int w, input bit mr,
        input bit pe_n, input bit cep_n, input bit cet_n,
        input bit auto_, input int unsigned d, output bit done);
        int unsigned ones;
        ones = (32'd1 << w) - 1;
        done = 1'b0;
        if (mr) return 0;
        if (!pe_n) return d;
        if (!cep_n && !cet_n) begin
            if (q != 0) return q - 1;
            done = 1'b1;
            return auto_ ? d : ones;
        end
        return q;
    endfunction

    always @(posedge CP) begin
        m4 = nxt(m4, 4, MR, b4.PE_n, b4.CEP_n, b4.CET_n,
                 b4.AUTO, b4.D, d4);
        m8 = nxt(m8, 8, MR, b8.PE_n, b8.CEP_n, b8.CET_n,
                 b8.AUTO, b8.D, d8);
    end

    always @(posedge CP) begin
        #2;
        check("q4", b4.Q, m4);
        check("done4", b4.DONE, d4);
        check("tc4", b4.TC, (m4 == 0) && !b4.CET_n);
        check("q8", b8.Q, m8);
        check("done8", b8.DONE, d8);
        check("tc8", b8.TC, (m8 == 0) && !b8.CET_n);
    end

    task automatic step();
        @(posedge CP);
        #3;
    endtask

    int unsigned exp_q1 [5]  = '{2, 1, 0, 15, 14};
    bit          exp_d1 [5]  = '{0, 0, 0, 1, 0};
    int unsigned exp_q2 [12] = '{4, 3, 2, 1, 0, 5, 4, 3, 2, 1, 0, 5};

    initial begin
        MR = 1'b1;
        b4.CEP_n = 1; b4.CET_n = 1; b4.PE_n = 1;
        b4.AUTO = 0; b4.D = '0;
        b8.CEP_n = 1; b8.CET_n = 1; b8.PE_n = 1;
        b8.AUTO = 0; b8.D = '0;

        step();
        check("rst_q", b4.Q, 0);
        check("rst_done", b4.DONE, 0);
        check("rst_tc", b4.TC, 0);

        // Load 3, count down through wrap with AUTO=0
        MR = 0; b4.PE_n = 0; b4.D = 4'd3;
        step();
        check("load3", b4.Q, 3);
        b4.PE_n = 1; b4.CEP_n = 0; b4.CET_n = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t1_q", b4.Q, exp_q1[i]);
            check("t1_done", b4.DONE, exp_d1[i]);
            check("t1_tc", b4.TC, exp_q1[i] == 0);
        end

        // Auto-reload divide-by-6
        b4.AUTO = 1; b4.D = 4'd5; b4.PE_n = 0;
        step();
        check("load5", b4.Q, 5);
        b4.PE_n = 1;
        for (int i = 0; i < 12; i++) begin
            step();
            check("t2_q", b4.Q, exp_q2[i]);
            check("t2_done", b4.DONE, (i == 5) || (i == 11));
        end

        // Reset beats load mid-count
        b4.CEP_n = 1; b4.PE_n = 0; b4.D = 4'd9;
        step();
        check("load9", b4.Q, 9);
        MR = 1; b4.D = 4'd7; b4.CEP_n = 0; b4.CET_n = 0;
        step();
        check("t3_q", b4.Q, 0);
        check("t3_done", b4.DONE, 0);
        check("t3_tc", b4.TC, 1);
        MR = 0; b4.PE_n = 1;

        // CET_n high blocks counting and TC
        b4.CET_n = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4_q", b4.Q, 0);
            check("t4_tc", b4.TC, 0);
            check("t4_done", b4.DONE, 0);
        end
        b4.CEP_n = 1; b4.CET_n = 0;
        #1;
        check("t4_tc_comb", b4.TC, 1);

        // 8-bit borrow across nibbles
        b4.CET_n = 1;
        b8.PE_n = 0; b8.D = 8'h10;
        step();
        check("load10", b8.Q, 8'h10);
        b8.PE_n = 1; b8.CEP_n = 0; b8.CET_n = 0;
        step();
        check("t5_q", b8.Q, 8'h0F);
        b8.PE_n = 0; b8.D = 8'h00;
        step();
        check("load00", b8.Q, 0);
        check("t5_tc", b8.TC, 1);
        b8.PE_n = 1;
        step();
        check("t5_wrap", b8.Q, 8'hFF);
        check("t5_done", b8.DONE, 1);
        b8.CEP_n = 1; b8.CET_n = 1;
        step();
        check("t5_done_off", b8.DONE, 0);

        // Load beats underflow
        b4.AUTO = 0; b4.D = 4'd0; b4.PE_n = 0;
        step();
        check("load0", b4.Q, 0);
        b4.D = 4'hA; b4.CEP_n = 0; b4.CET_n = 0;
        step();
        check("t6_q", b4.Q, 4'hA);
        check("t6_done", b4.DONE, 0);
        b4.PE_n = 1;
        step();
        check("t6_cnt", b4.Q, 4'h9);
        step();
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
